serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: computes A - B one bit per clock, LSB first.
//   The datapath is a single full-subtractor cell (two half-subtractors) plus a borrow flip-flop.

---
 rtl/serial_subtractor.sv | 166 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor: computes A - B one bit per clock,
//   LSB first, using a single full-subtractor cell (two half-subtractors) and a
//   borrow flip-flop. Sits behind a start/done handshake.
//
//   Latency: start sampled at edge E0, bits processed at E0+1 .. E0+WIDTH,
//   o_w_done high for the cycle after E0+WIDTH. Start held high gives one
//   result every WIDTH+1 cycles.
//
// Parameters
//   WIDTH        operand/result width in bits (>= 2)
//
// Optional feature
//   SERIAL_SUB_OVF_EN  when defined, adds o_w_ovf (signed overflow flag, held
//                      alongside o_w_diff). Undefined by default.
//
// Ports
//   i_w_clk    in   1      clock, rising edge
//   i_w_reset  in   1      synchronous active-high reset
//   i_w_start  in   1      request, sampled only while not busy
//   i_w_a      in   WIDTH  minuend, captured on the accepting edge
//   i_w_b      in   WIDTH  subtrahend, captured on the accepting edge
//   o_w_busy   out  1      high while shifting
//   o_w_done   out  1      one-cycle completion pulse
//   o_w_diff   out  WIDTH  A - B mod 2^WIDTH, held until next completion
//   o_w_bout   out  1      final borrow (A < B unsigned), held like o_w_diff
//   o_w_ovf    out  1      signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic [WIDTH-1:0] o_w_diff,
  output logic             o_w_bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_w_ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // minuend shifter, refilled with result bits
  logic [WIDTH-1:0] b_q, b_d;       // subtrahend shifter
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell built from two half-subtractors.
  logic bit_a, bit_b;
  logic hs1_d, hs1_b, cell_d, hs2_b, cell_bout;

  assign bit_a     = a_q[0];
  assign bit_b     = b_q[0];
  assign hs1_d     = bit_a ^ bit_b;
  assign hs1_b     = ~bit_a & bit_b;
  assign cell_d    = hs1_d ^ borrow_q;
  assign hs2_b     = ~hs1_d & borrow_q;
  assign cell_bout = hs1_b | hs2_b;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_w_start) begin
          state_d  = S_SHIFT;
          a_d      = i_w_a;
          b_d      = i_w_b;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end

      S_SHIFT: begin
        // Result bits enter the minuend register from the top as its own bits
        // leave from the bottom, so after WIDTH steps it holds the difference.
        a_d      = {cell_d, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          cnt_d   = '0;
          diff_d  = {cell_d, a_q[WIDTH-1:1]};
          bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
          // On the last step the cell sees the sign bits of A, B and diff.
          ovf_d   = (bit_a ^ bit_b) & (bit_a ^ cell_d);
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Decoded straight from the state register, so these are glitch-free.
  assign o_w_busy = (state_q == S_SHIFT);
  assign o_w_done = (state_q == S_DONE);
  assign o_w_diff = diff_q;
  assign o_w_bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign o_w_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH = 8): directed vector
//   table, randomized operands against an arithmetic reference model, and
//   hand-written sequences for busy-time start, back-to-back and reset abort.
//   Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         i_w_clk;
  logic         i_w_reset;
  logic         i_w_start;
  logic [W-1:0] i_w_a;
  logic [W-1:0] i_w_b;
  logic         o_w_busy;
  logic         o_w_done;
  logic [W-1:0] o_w_diff;
  logic         o_w_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         o_w_ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .i_w_clk   (i_w_clk),
    .i_w_reset (i_w_reset),
    .i_w_start (i_w_start),
    .i_w_a     (i_w_a),
    .i_w_b     (i_w_b),
    .o_w_busy  (o_w_busy),
    .o_w_done  (o_w_done),
    .o_w_diff  (o_w_diff),
    .o_w_bout  (o_w_bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .o_w_ovf   (o_w_ovf)
`endif
  );

  initial i_w_clk = 1'b0;
  always #5 i_w_clk = ~i_w_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Values the held outputs must show until the next completion.
  logic [W-1:0] hold_diff;
  logic         hold_bout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sa - sb;
    d  = W'(ua - ub);
    bo = (ua < ub);
    ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
  endtask

  // One operation: presents operands, scrambles them after capture, checks
  // busy and held outputs during the shift, and checks the done latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic bo, output logic ov);
    int k;
    @(negedge i_w_clk);
    i_w_start = 1'b1;
    i_w_a     = a;
    i_w_b     = b;
    @(posedge i_w_clk);
    #1;
    i_w_start = 1'b0;
    i_w_a     = W'($urandom);
    i_w_b     = W'($urandom);
    check("busy_after_start", 32'(o_w_busy), 32'd1);
    for (k = 1; k <= 4 * W; k++) begin
      @(posedge i_w_clk);
      #1;
      if (o_w_done) break;
      check("busy_in_shift", 32'(o_w_busy), 32'd1);
      check("diff_stable_in_shift", 32'(o_w_diff), 32'(hold_diff));
      check("bout_stable_in_shift", 32'(o_w_bout), 32'(hold_bout));
    end
    check("done_latency", 32'(k), 32'(W));
    check("busy_low_in_done", 32'(o_w_busy), 32'd0);
    d  = o_w_diff;
    bo = o_w_bout;
`ifdef SERIAL_SUB_OVF_EN
    ov = o_w_ovf;
`else
    ov = 1'b0;
`endif
  endtask

  vec_t         vecs[6];
  vec_t         ovf_vecs[3];
  logic [W-1:0] ra, rb, ed, gd;
  logic         eb, eo, gb, go;
  int           k, busy_cnt, done_seen, last_done, idle_gap, extra_done;
  logic [W-1:0] b2b_exp[3];

  initial begin
    vecs[0] = '{a: 8'd100, b: 8'd37,  diff: 8'd63,  bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'd37,  b: 8'd100, diff: 8'd193, bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'hFF,  b: 8'hFF,  diff: 8'h00,  bout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 8'h00,  b: 8'h01,  diff: 8'hFF,  bout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 8'hAA,  b: 8'h55,  diff: 8'h55,  bout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h01,  b: 8'hFF,  diff: 8'h02,  bout: 1'b1, ovf: 1'b0};
    ovf_vecs[0] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
    ovf_vecs[1] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, bout: 1'b1, ovf: 1'b1};
    ovf_vecs[2] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bout: 1'b0, ovf: 1'b0};

    // Reset state
    i_w_reset = 1'b1;
    i_w_start = 1'b0;
    i_w_a     = '0;
    i_w_b     = '0;
    repeat (2) @(posedge i_w_clk);
    #1;
    check("reset_busy", 32'(o_w_busy), 32'd0);
    check("reset_done", 32'(o_w_done), 32'd0);
    check("reset_diff", 32'(o_w_diff), 32'd0);
    check("reset_bout", 32'(o_w_bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(o_w_ovf), 32'd0);
`endif
    @(negedge i_w_clk);
    i_w_reset = 1'b0;
    hold_diff = '0;
    hold_bout = 1'b0;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, gd, gb, go);
      check("vec_diff", 32'(gd), 32'(vecs[i].diff));
      check("vec_bout", 32'(gb), 32'(vecs[i].bout));
`ifdef SERIAL_SUB_OVF_EN
      check("vec_ovf", 32'(go), 32'(vecs[i].ovf));
`endif
      hold_diff = vecs[i].diff;
      hold_bout = vecs[i].bout;
    end

`ifdef SERIAL_SUB_OVF_EN
    for (int i = 0; i < 3; i++) begin
      run_op(ovf_vecs[i].a, ovf_vecs[i].b, gd, gb, go);
      check("ovf_diff", 32'(gd), 32'(ovf_vecs[i].diff));
      check("ovf_flag", 32'(go), 32'(ovf_vecs[i].ovf));
      hold_diff = ovf_vecs[i].diff;
      hold_bout = ovf_vecs[i].bout;
    end
`endif

    // Randomized operands against the model
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      model(ra, rb, ed, eb, eo);
      run_op(ra, rb, gd, gb, go);
      check("rand_diff", 32'(gd), 32'(ed));
      check("rand_bout", 32'(gb), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
      check("rand_ovf", 32'(go), 32'(eo));
`endif
      hold_diff = ed;
      hold_bout = eb;
    end

    // Start pulses with new operands on every busy cycle are ignored.
    @(negedge i_w_clk);
    i_w_start = 1'b1;
    i_w_a     = 8'd100;
    i_w_b     = 8'd37;
    @(posedge i_w_clk);
    #1;
    busy_cnt = o_w_busy ? 1 : 0;
    for (k = 1; k <= 4 * W; k++) begin
      i_w_start = 1'b1;
      i_w_a     = W'($urandom);
      i_w_b     = W'($urandom);
      @(posedge i_w_clk);
      #1;
      if (o_w_done) break;
      if (o_w_busy) busy_cnt++;
    end
    i_w_start = 1'b0;
    check("busy_start_latency", 32'(k), 32'(W));
    check("busy_start_busy_cycles", 32'(busy_cnt), 32'(W));
    check("busy_start_diff", 32'(o_w_diff), 32'd63);
    check("busy_start_bout", 32'(o_w_bout), 32'd0);
    hold_diff = 8'd63;
    hold_bout = 1'b0;

    // Start held high for three back-to-back operations.
    b2b_exp[0] = 8'd7;
    b2b_exp[1] = 8'd249;
    b2b_exp[2] = 8'd0;
    repeat (2) @(posedge i_w_clk);
    @(negedge i_w_clk);
    i_w_start = 1'b1;
    i_w_a     = 8'd10;
    i_w_b     = 8'd3;
    @(posedge i_w_clk);
    #1;
    i_w_a     = 8'hC3;
    i_w_b     = 8'h5A;
    done_seen = 0;
    last_done = 0;
    idle_gap  = 0;
    for (int c = 1; c <= 40 && done_seen < 3; c++) begin
      @(posedge i_w_clk);
      #1;
      if (o_w_done) begin
        check("b2b_diff", 32'(o_w_diff), 32'(b2b_exp[done_seen]));
        if (done_seen == 0) check("b2b_first_latency", 32'(c), 32'(W));
        else check("b2b_done_spacing", 32'(c - last_done), 32'(W + 1));
        check("b2b_busy_low_in_done", 32'(o_w_busy), 32'd0);
        last_done = c;
        done_seen++;
        if (done_seen == 1) begin
          i_w_a = 8'd3;
          i_w_b = 8'd10;
        end else if (done_seen == 2) begin
          i_w_a = 8'd0;
          i_w_b = 8'd0;
        end else begin
          i_w_start = 1'b0;
        end
      end else if (!o_w_busy) begin
        idle_gap++;
      end
    end
    i_w_start = 1'b0;
    check("b2b_done_count", 32'(done_seen), 32'd3);
    check("b2b_no_idle_gap", 32'(idle_gap), 32'd0);
    hold_diff = 8'd0;
    hold_bout = 1'b0;

    // Reset during the fourth shift cycle aborts the operation.
    run_op(8'd100, 8'd37, gd, gb, go);
    check("pre_abort_diff", 32'(gd), 32'd63);
    @(negedge i_w_clk);
    i_w_start = 1'b1;
    i_w_a     = 8'd200;
    i_w_b     = 8'd1;
    @(posedge i_w_clk);
    #1;
    i_w_start = 1'b0;
    repeat (3) @(posedge i_w_clk);
    #1;
    i_w_reset = 1'b1;
    @(posedge i_w_clk);
    #1;
    check("abort_busy", 32'(o_w_busy), 32'd0);
    check("abort_done", 32'(o_w_done), 32'd0);
    check("abort_diff", 32'(o_w_diff), 32'd0);
    check("abort_bout", 32'(o_w_bout), 32'd0);
    @(negedge i_w_clk);
    i_w_reset  = 1'b0;
    extra_done = 0;
    for (int c = 0; c < 2 * W; c++) begin
      @(posedge i_w_clk);
      #1;
      if (o_w_done) extra_done++;
    end
    check("abort_no_done", 32'(extra_done), 32'd0);
    hold_diff = '0;
    hold_bout = 1'b0;
    run_op(8'd50, 8'd20, gd, gb, go);
    check("post_abort_diff", 32'(gd), 32'd30);
    check("post_abort_bout", 32'(gb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
